// File: rtl/rom_stream_reader.sv
// Reads a run of consecutive ROM words and streams them out over valid/ready.
// Each word costs one FETCH cycle plus one or more HOLD cycles; FIN emits done.
module rom_stream_reader #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              w_fetch;

  // ROM strobes exist only during FETCH; address is parked at 0 otherwise
  assign w_fetch   = (r_state == S_FETCH);
  assign rom_cs    = w_fetch;
  assign rom_rd_en = w_fetch;
  assign rom_addr  = w_fetch ? r_addr : '0;

  assign out_data  = r_data;
  assign out_last  = r_last;
  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);

  // Sequencer; abort outranks the stream handshake in FETCH and HOLD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_addr  <= base_addr;
              r_rem   <= count;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_data  <= rom_data;
            r_last  <= (r_rem == CNT_W'(1));
            r_addr  <= r_addr + ADDR_W'(1);
            r_rem   <= r_rem - CNT_W'(1);
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (out_ready) begin
            r_state <= r_last ? S_FIN : S_FETCH;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomized bench for rom_stream_reader: a list of expected words and a cycle
// budget per run are computed up front from the base/count/stall plan.
module tb_rom_stream_reader;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic       abort     = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] base_addr = '0;
  logic [3:0] count     = '0;
  logic [2:0] rom_addr;
  logic       rom_cs;
  logic       rom_rd_en;
  wire  [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [8];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign rom_data = (rom_cs && rom_rd_en) ? mem[rom_addr] : 8'hzz;

  rom_stream_reader #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .count     (count),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_rd_en (rom_rd_en),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // The i-th word of a run starting at b, with the address wrapping mod 8
  function automatic int exp_word(input int b, input int i);
    return 16 + ((b + i) % 8);
  endfunction

  function automatic logic [31:0] all_outputs();
    return 32'({rom_addr, rom_cs, rom_rd_en, out_data, out_valid, out_last, busy, done});
  endfunction

  // One run: per-word stall counts are drawn first, giving the exact busy length
  task automatic run(input int b, input int n, input int max_stall, input int first_stall,
                     input bit poke_start, input bit abort_with_start);
    int stalls[$];
    int exp_busy   = 1;
    int widx       = 0;
    int stall_left = 0;
    int busy_cyc   = 0;
    int done_cyc   = 0;
    int done_t     = -1;
    int fetch_cyc  = 0;
    int overlap    = 0;
    int first_v    = -1;
    for (int i = 0; i < n; i++) begin
      int s;
      s = (i == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(0, max_stall));
      stalls.push_back(s);
      exp_busy += 2 + s;
    end
    if (n > 0) stall_left = stalls[0];
    @(negedge clk);
    start     = 1'b1;
    base_addr = 3'(b);
    count     = 4'(n);
    abort     = abort_with_start;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int t = 1; t <= exp_busy + 2; t++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc++;
        done_t = t;
      end
      if (rom_cs) begin
        fetch_cyc++;
        check("rom_addr", 32'(rom_addr), 32'((b + widx) % 8));
      end
      if (rom_cs !== rom_rd_en) check("rom_rd_en", 32'(rom_rd_en), 32'(rom_cs));
      if (rom_cs && out_valid) overlap++;
      if (poke_start && t == 3) begin
        start     = 1'b1;
        base_addr = 3'd5;
        count     = 4'd7;
      end
      if (out_valid) begin
        if (first_v < 0) first_v = t;
        if (widx < n) begin
          check("out_data", 32'(out_data), 32'(exp_word(b, widx)));
          check("out_last", 32'(out_last), 32'(widx == n - 1));
        end else begin
          check("extra_word", 32'(widx), 32'(n - 1));
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          widx++;
          if (widx < n) stall_left = stalls[widx];
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    check("words_accepted", 32'(widx), 32'(n));
    check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
    check("done_cycle", 32'(done_t), 32'(exp_busy));
    check("done_pulses", 32'(done_cyc), 32'd1);
    check("fetch_cycles", 32'(fetch_cyc), 32'(n));
    check("fetch_while_valid", 32'(overlap), 32'd0);
    if (n > 0) check("first_valid_cycle", 32'(first_v), 32'd2);
  endtask

  // Abort during the HOLD of the third word of an 8-word run
  task automatic abort_run();
    int  widx     = 0;
    int  done_cyc = 0;
    bit  aborted  = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = 3'd0;
    count     = 4'd8;
    out_ready = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 40 && !aborted; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cyc++;
      if (out_valid) begin
        if (widx == 2) begin
          check("abort_hold_data", 32'(out_data), 32'(exp_word(0, 2)));
          abort   = 1'b1;
          aborted = 1'b1;
        end else begin
          check("abort_data", 32'(out_data), 32'(exp_word(0, widx)));
          widx++;
        end
      end
    end
    check("abort_reached", 32'(aborted), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) done_cyc++;
    end
    check("abort_no_done", 32'(done_cyc), 32'd0);
  endtask

  // Reset asserted while the first FETCH is on the ROM bus
  task automatic reset_run();
    int late = 0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = 3'd3;
    count     = 4'd3;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("rst_fetch_cs", 32'(rom_cs), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_outputs", all_outputs(), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy || out_valid) late++;
    end
    check("rst_idle_after", 32'(late), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(16 + i);
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 32'd0);
    rst_n = 1'b1;
    run(2, 3, 0, -1, 1'b0, 1'b0);
    run(6, 4, 0, -1, 1'b0, 1'b0);
    run(0, 2, 0, 5, 1'b0, 1'b0);
    run(4, 0, 0, -1, 1'b0, 1'b0);
    run(0, 3, 0, -1, 1'b1, 1'b0);
    abort_run();
    run(1, 5, 1, -1, 1'b0, 1'b0);
    reset_run();
    run(7, 15, 0, -1, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) begin
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 3, -1,
          1'b0, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
